// File: rtl/intrapred_pkg.sv
// Shared definitions for the intra-prediction residue save/read path:
// frame and macroblock defaults, macroblock count helper, mode and reader
// state encodings.
package intrapred_pkg;

  localparam int unsigned LENGTH_DEF    = 1280;
  localparam int unsigned WIDTH_DEF     = 720;
  localparam int unsigned MB_SIZE_L_DEF = 8;
  localparam int unsigned MB_SIZE_W_DEF = 8;
  localparam int unsigned MBN_BITS_DEF  = 14;
  localparam int unsigned ADDR_BITS_DEF = 20;

  // 3-bit prediction mode as held in the mode store.
  typedef enum logic [2:0] {
    MODE_VERTICAL   = 3'd0,
    MODE_HORIZONTAL = 3'd1,
    MODE_DC         = 3'd2,
    MODE_DIAG_DL    = 3'd3,
    MODE_DIAG_DR    = 3'd4,
    MODE_VERT_RIGHT = 3'd5,
    MODE_HORIZ_DOWN = 3'd6,
    MODE_VERT_LEFT  = 3'd7
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    FETCH = 2'd2,
    DRAIN = 2'd3
  } rd_state_t;

  // Number of macroblocks in one frame.
  function automatic int unsigned calc_nmb(input int unsigned length,
                                           input int unsigned width,
                                           input int unsigned mb_l,
                                           input int unsigned mb_w);
    return (length / mb_l) * (width / mb_w);
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry synchronous FIFO carrying an 8-bit residue plus a last flag,
// valid/ready on both sides. The head entry drives the outputs directly so
// they stay stable while the consumer stalls.
module skid_fifo2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [1:0] count
);

  logic [8:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       push;
  logic       pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign {out_last, out_data} = mem[rd_ptr];
  assign count     = cnt;

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage is reset because its head entry drives out_data and
      // out_last, which must read zero straight after reset.
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_last, in_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mb_residue_reader.sv
// Reads one macroblock's prediction mode and residue block from the frame
// stores and streams the residues in raster order over valid/ready.
module mb_residue_reader
  import intrapred_pkg::*;
#(
  parameter int unsigned LENGTH    = LENGTH_DEF,
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned MB_SIZE_L = MB_SIZE_L_DEF,
  parameter int unsigned MB_SIZE_W = MB_SIZE_W_DEF,
  parameter int unsigned MBN_BITS  = MBN_BITS_DEF,
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MBN_BITS-1:0]  mbnumber,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 res_rd_en,
  output logic [ADDR_BITS-1:0] res_rd_addr,
  input  logic [7:0]           res_rd_data,
  output logic                 mode_rd_en,
  output logic [MBN_BITS-1:0]  mode_rd_addr,
  input  logic [2:0]           mode_rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic [2:0]           out_mode,
  output logic                 out_last
);

  localparam int unsigned MBS_PER_ROW = LENGTH / MB_SIZE_L;
  localparam int unsigned NMB         = calc_nmb(LENGTH, WIDTH, MB_SIZE_L, MB_SIZE_W);
  localparam logic [4:0]  X_LAST      = 5'(MB_SIZE_L - 1);
  localparam logic [4:0]  Y_LAST      = 5'(MB_SIZE_W - 1);

  rd_state_t            state, state_nx;
  logic [MBN_BITS-1:0]  mbn_q;
  logic [ADDR_BITS-1:0] row_base;
  logic [4:0]           x_q, y_q;
  logic                 first_fetch;
  logic                 rd_pend, rd_pend_last, mode_pend;
  mode_t                mode_q;
  logic                 done_q, err_q;
  logic                 accept, reject, last_issue, issue_ok;
  logic [31:0]          mb_row, mb_col;
  logic [2:0]           pending_cnt;
  logic [1:0]           fifo_count;
  logic                 fifo_in_ready;
  logic                 fire;

  assign busy         = (state != IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign out_mode     = mode_q;
  assign fire         = out_valid && out_ready;
  assign last_issue   = (x_q == X_LAST) && (y_q == Y_LAST);
  assign res_rd_addr  = res_rd_en  ? row_base + ADDR_BITS'(x_q) : '0;
  assign mode_rd_addr = mode_rd_en ? mbn_q : '0;
  assign mb_row       = 32'(mbn_q) / MBS_PER_ROW;
  assign mb_col       = 32'(mbn_q) % MBS_PER_ROW;

  // Beats buffered or already on their way, net of the one leaving this cycle.
  assign pending_cnt = {1'b0, fifo_count} + {2'b00, rd_pend} - {2'b00, fire};
  assign issue_ok    = (pending_cnt < 3'd2) && (fifo_in_ready || fire);

  // Next state, request accept/reject and store read strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned, which would infer a latch.
    state_nx   = state;
    accept     = 1'b0;
    reject     = 1'b0;
    res_rd_en  = 1'b0;
    mode_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (32'(mbnumber) < NMB) begin
            accept   = 1'b1;
            state_nx = ADDR;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ADDR: state_nx = FETCH;
      FETCH: begin
        mode_rd_en = first_fetch;
        if (issue_ok) begin
          res_rd_en = 1'b1;
          if (last_issue) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (fire && out_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, block addressing counters and read-return tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mbn_q        <= '0;
      row_base     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      first_fetch  <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      mode_pend    <= 1'b0;
      mode_q       <= MODE_VERTICAL;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of the others.
      state        <= state_nx;
      done_q       <= (state == DRAIN) && fire && out_last;
      err_q        <= reject;
      first_fetch  <= (state == ADDR);
      rd_pend      <= res_rd_en;
      rd_pend_last <= res_rd_en && last_issue;
      mode_pend    <= mode_rd_en;
      if (accept) mbn_q <= mbnumber;
      if (mode_pend) mode_q <= mode_t'(mode_rd_data);
      if (state == ADDR) begin
        row_base <= ADDR_BITS'(mb_row * MB_SIZE_W * LENGTH + mb_col * MB_SIZE_L);
        x_q      <= '0;
        y_q      <= '0;
      end else if (res_rd_en) begin
        if (x_q == X_LAST) begin
          x_q      <= '0;
          y_q      <= y_q + 5'd1;
          row_base <= row_base + ADDR_BITS'(LENGTH);
        end else begin
          x_q <= x_q + 5'd1;
        end
      end
    end
  end

  skid_fifo2 u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_pend),
    .in_ready  (fifo_in_ready),
    .in_data   (res_rd_data),
    .in_last   (rd_pend_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_mb_residue_reader.sv
// Self-checking bench for mb_residue_reader: behavioural stores, scoreboard
// queues of expected addresses and beats, timing and hold checks.
module tb_mb_residue_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] mbnumber;
  logic        busy, done, err;
  logic        res_rd_en;
  logic [19:0] res_rd_addr;
  logic [7:0]  res_rd_data;
  logic        mode_rd_en;
  logic [13:0] mode_rd_addr;
  logic [2:0]  mode_rd_data;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_data;
  logic [2:0]  out_mode;

  mb_residue_reader #(
    .LENGTH(1280), .WIDTH(720), .MB_SIZE_L(8), .MB_SIZE_W(8),
    .MBN_BITS(14), .ADDR_BITS(20)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mbnumber(mbnumber),
    .busy(busy), .done(done), .err(err),
    .res_rd_en(res_rd_en), .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
    .mode_rd_en(mode_rd_en), .mode_rd_addr(mode_rd_addr), .mode_rd_data(mode_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mode(out_mode), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] store_val(input logic [19:0] a);
    return a[7:0];
  endfunction

  function automatic logic [2:0] mode_of(input logic [13:0] m);
    if (m == 14'd161) return 3'd5;
    return m[2:0] + 3'd3;
  endfunction

  // Synchronous-read store models, one cycle of latency.
  always @(posedge clk) begin
    if (res_rd_en)  res_rd_data  <= store_val(res_rd_addr);
    if (mode_rd_en) mode_rd_data <= mode_of(mode_rd_addr);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer ready: held high, or a fair coin each cycle.
  bit rand_ready = 1'b0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic [19:0] addr_q[$];
  logic [8:0]  beat_q[$];
  logic [2:0]  exp_mode;
  logic [13:0] exp_mbn;
  int          c0;
  bit          first_rd_pend, first_mode_pend, first_val_pend;
  int          beats_seen, rd_seen, mode_seen;
  bit          done_seen;
  bit          prev_stall;
  logic [7:0]  held_data;
  logic        held_last;
  logic [2:0]  held_mode;
  logic [8:0]  b;

  // Output monitor: read addresses, beat scoreboard, hold-under-stall, timing.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (res_rd_en) begin
        rd_seen++;
        if (addr_q.size() == 0) check("rd_unexpected", 64'(res_rd_en), 64'(0));
        else check("rd_addr", 64'(res_rd_addr), 64'(addr_q.pop_front()));
        if (first_rd_pend) begin
          check("first_rd_cycle", 64'(cyc - c0), 64'(2));
          first_rd_pend = 1'b0;
        end
      end
      if (mode_rd_en) begin
        mode_seen++;
        check("mode_rd_addr", 64'(mode_rd_addr), 64'(exp_mbn));
        if (first_mode_pend) begin
          check("mode_rd_cycle", 64'(cyc - c0), 64'(2));
          first_mode_pend = 1'b0;
        end
      end
      if (out_valid && first_val_pend) begin
        check("first_valid_cycle", 64'(cyc - c0), 64'(4));
        first_val_pend = 1'b0;
      end
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_data",  64'(out_data),  64'(held_data));
        check("hold_last",  64'(out_last),  64'(held_last));
        check("hold_mode",  64'(out_mode),  64'(held_mode));
      end
      if (out_valid && out_ready) begin
        if (beat_q.size() == 0) check("beat_unexpected", 64'(out_valid), 64'(0));
        else begin
          b = beat_q.pop_front();
          check("beat_data", 64'(out_data), 64'(b[7:0]));
          check("beat_last", 64'(out_last), 64'(b[8]));
          check("beat_mode", 64'(out_mode), 64'(exp_mode));
        end
        beats_seen++;
      end
      prev_stall = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
      held_mode  = out_mode;
      if (done) done_seen = 1'b1;
    end
  end

  task automatic push_expect(input logic [13:0] mbn);
    int row, col, base, a;
    row  = int'(mbn) / 160;
    col  = int'(mbn) % 160;
    base = row * 8 * 1280 + col * 8;
    for (int k = 0; k < 64; k++) begin
      a = base + (k / 8) * 1280 + (k % 8);
      addr_q.push_back(20'(a));
      beat_q.push_back({(k == 63), store_val(20'(a))});
    end
    exp_mode        = mode_of(mbn);
    exp_mbn         = mbn;
    rd_seen         = 0;
    mode_seen       = 0;
    beats_seen      = 0;
    done_seen       = 1'b0;
    first_rd_pend   = 1'b1;
    first_mode_pend = 1'b1;
    first_val_pend  = 1'b1;
  endtask

  // Issue one request at a falling edge and wait (bounded) for done.
  task automatic run_block(input logic [13:0] mbn, input bit timed);
    bit got;
    push_expect(mbn);
    c0       = cyc;
    start    = 1'b1;
    mbnumber = mbn;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("busy_cycle1", 64'(busy), 64'(1));
    check("err_cycle1",  64'(err),  64'(0));
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) check("done_timeout", 64'(done), 64'(1));
    else begin
      if (timed) check("done_cycle", 64'(cyc - c0), 64'(68));
      check("busy_at_done", 64'(busy), 64'(0));
      check("beats_left",   64'(beat_q.size()), 64'(0));
      check("addrs_left",   64'(addr_q.size()), 64'(0));
      check("mode_reads",   64'(mode_seen), 64'(1));
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, done, err, res_rd_en, mode_rd_en, out_valid, out_last,
                out_data, out_mode, res_rd_addr, mode_rd_addr});
  endfunction

  initial begin
    bit hit;
    reset    = 1'b1;
    start    = 1'b0;
    mbnumber = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", all_outs(), 64'(0));
    repeat (2) @(negedge clk);

    // Default block, full-rate consumer; the next two starts land on done.
    run_block(14'd0, 1'b1);
    run_block(14'd161, 1'b1);
    run_block(14'd14399, 1'b1);

    // Out-of-range request.
    exp_mbn   = 14'd14400;
    rd_seen   = 0;
    mode_seen = 0;
    start     = 1'b1;
    mbnumber  = 14'd14400;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("err_pulse", 64'(err), 64'(1));
    check("err_busy",  64'(busy), 64'(0));
    @(negedge clk);
    check("err_one_cycle", 64'(err), 64'(0));
    repeat (6) begin
      @(negedge clk);
      check("err_busy_low", 64'(busy), 64'(0));
    end
    check("err_no_res_rd",  64'(rd_seen),   64'(0));
    check("err_no_mode_rd", 64'(mode_seen), 64'(0));

    // Random backpressure on the default block.
    rand_ready = 1'b1;
    run_block(14'd0, 1'b0);
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Abort mid-stream with reset.
    push_expect(14'd0);
    c0       = cyc;
    start    = 1'b1;
    mbnumber = 14'd0;
    @(posedge clk);
    #1 start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (beats_seen >= 21) hit = 1'b1;
    end
    if (!hit) check("abort_beat_timeout", 64'(beats_seen), 64'(21));
    reset = 1'b1;
    #1;
    check("abort_outputs_zero", all_outs(), 64'(0));
    addr_q.delete();
    beat_q.delete();
    done_seen = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_outputs_held", all_outs(), 64'(0));
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_done", 64'(done_seen), 64'(0));
    check("abort_idle",    64'(busy),      64'(0));

    // Clean restart after the abort.
    run_block(14'd1, 1'b1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
    $fatal(1, "watchdog");
  end

endmodule
